// File: rtl/mem_read_arbiter.sv
// Two-port read arbiter in front of a combinational word memory, with wait states and misalignment rejection.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_read_arbiter #(
  parameter int WORD_SIZE_BYTES = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         p0_req,
  input  logic [ADDR_WIDTH-1:0]        p0_addr,
  output logic                         p0_ack,
  input  logic                         p1_req,
  input  logic [ADDR_WIDTH-1:0]        p1_addr,
  output logic                         p1_ack,
  output logic [WORD_SIZE_BYTES*8-1:0] rdata,
  output logic                         err,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [WORD_SIZE_BYTES*8-1:0] mem_data,
  output logic                         busy
);

  localparam int DATA_W = WORD_SIZE_BYTES * 8;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(WORD_SIZE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  port_q, port_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_W-1:0]     rdata_nxt;
  logic                  err_nxt;
  logic                  any_req;
  logic                  tie_p1;
  logic                  grant_p1;
  logic [ADDR_WIDTH-1:0] grant_addr;

  function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] a);
    return |(a & OFF_MASK);
  endfunction

  assign any_req = p0_req | p1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Resets to port 1 so that port 0 takes the first tie.
  logic last_grant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (state == IDLE && any_req)
      last_grant <= grant_p1;
  end
  assign tie_p1 = ~last_grant;
`else
  assign tie_p1 = 1'b0;
`endif

  assign grant_p1   = p1_req & (~p0_req | tie_p1);
  assign grant_addr = grant_p1 ? p1_addr : p0_addr;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    port_nxt  = port_q;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (any_req) begin
          addr_nxt = grant_addr;
          port_nxt = grant_p1;
          // Misaligned requests skip the memory entirely and answer next cycle.
          if (misaligned(grant_addr)) begin
            rdata_nxt = '0;
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          rdata_nxt = mem_data;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      port_q <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      port_q <= port_nxt;
      cnt    <= cnt_nxt;
      rdata  <= rdata_nxt;
      err    <= err_nxt;
    end
  end

  // The latched address is only observed while in ACCESS, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_nxt;
  end

  assign mem_addr = (state == ACCESS) ? addr_q : '0;
  assign p0_ack   = (state == RESP) & ~port_q;
  assign p1_ack   = (state == RESP) & port_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: two instances (WAIT_CYCLES=2 and 0) sharing one byte memory.
module tb_mem_read_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q2[$];
  exp_t        q0[$];
  logic [7:0]  mem [0:255];

  logic        p0_req2, p1_req2, p0_ack2, p1_ack2, err2, busy2;
  logic [31:0] p0_addr2, p1_addr2, rdata2, maddr2, mdata2;
  logic        p0_req0, p1_req0, p0_ack0, p1_ack0, err0, busy0;
  logic [31:0] p0_addr0, p1_addr0, rdata0, maddr0, mdata0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mdata2 = {mem[maddr2[7:0]], mem[maddr2[7:0] + 8'd1], mem[maddr2[7:0] + 8'd2], mem[maddr2[7:0] + 8'd3]};
  assign mdata0 = {mem[maddr0[7:0]], mem[maddr0[7:0] + 8'd1], mem[maddr0[7:0] + 8'd2], mem[maddr0[7:0] + 8'd3]};

  mem_read_arbiter #(.WORD_SIZE_BYTES(4), .ADDR_WIDTH(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req2), .p0_addr(p0_addr2), .p0_ack(p0_ack2),
    .p1_req(p1_req2), .p1_addr(p1_addr2), .p1_ack(p1_ack2),
    .rdata(rdata2), .err(err2), .mem_addr(maddr2), .mem_data(mdata2), .busy(busy2)
  );

  mem_read_arbiter #(.WORD_SIZE_BYTES(4), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req0), .p0_addr(p0_addr0), .p0_ack(p0_ack0),
    .p1_req(p1_req0), .p1_addr(p1_addr0), .p1_ack(p1_ack0),
    .rdata(rdata0), .err(err0), .mem_addr(maddr0), .mem_data(mdata0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push2(input logic port, input logic [31:0] data, input logic e, input int at);
    exp_t t;
    t.port = port; t.data = data; t.err = e; t.cyc = at;
    q2.push_back(t);
  endtask

  task automatic push0(input logic port, input logic [31:0] data, input logic e, input int at);
    exp_t t;
    t.port = port; t.data = data; t.err = e; t.cyc = at;
    q0.push_back(t);
  endtask

  // Monitors: every ack must match the head of its instance's queue.
  always @(negedge clk) begin
    if (p0_ack2 || p1_ack2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL d2_unexpected_ack: got p0=%b p1=%b want none", p0_ack2, p1_ack2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2_p0_ack", {31'd0, p0_ack2}, {31'd0, ~e.port});
        chk("d2_p1_ack", {31'd0, p1_ack2}, {31'd0, e.port});
        chk("d2_rdata", rdata2, e.data);
        chk("d2_err", {31'd0, err2}, {31'd0, e.err});
        chk("d2_ack_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (p0_ack0 || p1_ack0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL d0_unexpected_ack: got p0=%b p1=%b want none", p0_ack0, p1_ack0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("d0_p0_ack", {31'd0, p0_ack0}, {31'd0, ~e.port});
        chk("d0_p1_ack", {31'd0, p1_ack0}, {31'd0, e.port});
        chk("d0_rdata", rdata0, e.data);
        chk("d0_err", {31'd0, err0}, {31'd0, e.err});
        chk("d0_ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h04] = 8'h55; mem[8'h05] = 8'h66; mem[8'h06] = 8'h77; mem[8'h07] = 8'h88;
    mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;
    reset = 1'b1;
    p0_req2 = 0; p1_req2 = 0; p0_addr2 = 0; p1_addr2 = 0;
    p0_req0 = 0; p1_req0 = 0; p0_addr0 = 0; p1_addr0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy2}, 32'd0);
    chk("rst_maddr", maddr2, 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_err", {31'd0, err2}, 32'd0);
    chk("rst_acks", {30'd0, p1_ack2, p0_ack2}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    reset = 1'b0;

    // p0 aligned read, WAIT_CYCLES=2
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h10;
    push2(1'b0, 32'hDEADBEEF, 1'b0, cyc + 4);
    @(negedge clk);
    chk("t1_maddr_c0", maddr2, 32'd0);
    chk("t1_busy_c0", {31'd0, busy2}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t1_maddr_access", maddr2, 32'h10);
      chk("t1_busy_access", {31'd0, busy2}, 32'd1);
    end
    @(negedge clk);
    chk("t1_maddr_resp", maddr2, 32'd0);
    chk("t1_p1_ack", {31'd0, p1_ack2}, 32'd0);
    chk("t1_p0_ack", {31'd0, p0_ack2}, 32'd1);
    p0_req2 = 0;

    // misaligned p0 read
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h12;
    push2(1'b0, 32'h0, 1'b1, cyc + 1);
    @(negedge clk);
    chk("mis_maddr_c0", maddr2, 32'd0);
    @(negedge clk);
    chk("mis_maddr_c1", maddr2, 32'd0);
    chk("mis_busy_c1", {31'd0, busy2}, 32'd1);
    p0_req2 = 0;

    // back-to-back p0 reads 0x00, 0x04
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h00;
    push2(1'b0, 32'h11223344, 1'b0, cyc + 4);
    repeat (5) @(negedge clk);
    p0_addr2 = 32'h04;
    push2(1'b0, 32'h55667788, 1'b0, cyc + 5);
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_rdata_hold", rdata2, 32'h11223344);
      chk("b2b_maddr", maddr2, (i == 5) ? 32'h0 : 32'h04);
    end
    @(negedge clk);
    chk("b2b_second_ack", {31'd0, p0_ack2}, 32'd1);
    p0_req2 = 0;

    // reset in the middle of an ACCESS; the read must never be acked
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h04;
    repeat (3) @(negedge clk);
    chk("rstmid_busy_pre", {31'd0, busy2}, 32'd1);
    chk("rstmid_maddr_pre", maddr2, 32'h04);
    reset = 1'b1;
    p0_req2 = 0;
    #1;
    chk("rstmid_maddr", maddr2, 32'd0);
    chk("rstmid_busy", {31'd0, busy2}, 32'd0);
    chk("rstmid_rdata", rdata2, 32'd0);
    chk("rstmid_err", {31'd0, err2}, 32'd0);
    chk("rstmid_acks", {30'd0, p1_ack2, p0_ack2}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // both ports requesting continuously for four transactions
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h00;
    p1_req2 = 1; p1_addr2 = 32'h20;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push2(1'b0, 32'h11223344, 1'b0, cyc + 4);
    push2(1'b1, 32'h01020304, 1'b0, cyc + 9);
    push2(1'b0, 32'h11223344, 1'b0, cyc + 14);
    push2(1'b1, 32'h01020304, 1'b0, cyc + 19);
`else
    push2(1'b0, 32'h11223344, 1'b0, cyc + 4);
    push2(1'b0, 32'h11223344, 1'b0, cyc + 9);
    push2(1'b0, 32'h11223344, 1'b0, cyc + 14);
    push2(1'b0, 32'h11223344, 1'b0, cyc + 19);
`endif
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (p0_ack2 || p1_ack2) acks++;
    end
    p0_req2 = 0; p1_req2 = 0;
    chk("contend_ack_count", acks, 32'd4);

    // p0 read after everything, normal latency
    @(posedge clk); #1;
    p0_req2 = 1; p0_addr2 = 32'h10;
    push2(1'b0, 32'hDEADBEEF, 1'b0, cyc + 4);
    acks = 0;
    for (int i = 0; i < 30 && acks == 0; i++) begin
      @(negedge clk);
      if (p0_ack2) acks = 1;
    end
    p0_req2 = 0;
    chk("final_read_acked", acks, 32'd1);

    // p1 read on the zero-wait instance
    @(posedge clk); #1;
    p1_req0 = 1; p1_addr0 = 32'h20;
    push0(1'b1, 32'h01020304, 1'b0, cyc + 2);
    @(negedge clk);
    chk("w0_busy_c0", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    chk("w0_busy_c1", {31'd0, busy0}, 32'd1);
    chk("w0_maddr_c1", maddr0, 32'h20);
    @(negedge clk);
    chk("w0_busy_c2", {31'd0, busy0}, 32'd1);
    chk("w0_p1_ack_c2", {31'd0, p1_ack0}, 32'd1);
    p1_req0 = 0;
    @(negedge clk);
    chk("w0_busy_c3", {31'd0, busy0}, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("q2_drained", q2.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
